rr_bus_arbiter: RTL
===================

Name: rr_bus_arbiter

Overview:
- Round-robin arbiter sharing one datapath resource among N_REQ requesters.
- Each requester asks for a burst of beats. Once granted, it owns the resource until one of three things happens: it completes its burst, it drops its request, or a watchdog expires.
- Sits between requester blocks and the shared resource. The resource reports beat completion back to this block.

Parameters:
- N_REQ, 4, number of requesters (≥1).
- BURST_W, 4, width of per-requester burst length field. Length is encoded as beats−1.
- TIMEOUT, 64, maximum consecutive owned cycles without a completed beat before forced release (≥2).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  N_REQ  per-requester request level.
- len_i  in  N_REQ*BURST_W  per-requester burst length (beats−1). Slice k belongs to requester k.
- beat_done_i  in  1  resource completed one beat for the current owner.
- gnt_o  out  N_REQ  one-hot grant, registered.
- gnt_id_o  out  $clog2(N_REQ) (min 1)  index of current/last owner.
- busy_o  out  1  resource owned (state OWN).
- timeout_o  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset (async assert, sync deassert internally):
  - gnt_o=0, gnt_id_o=0, busy_o=0, timeout_o=0.
  - Priority pointer=0, beat count=0, watchdog=0, state=IDLE.
- States:
  - IDLE: no owner. If req_i≠0, select the first set bit at or after the pointer, wrapping modulo N_REQ. Latch its len_i slice, load gnt_o/gnt_id_o, go to OWN. A request seen in cycle t gives a grant visible at t+1.
  - OWN: gnt_o one-hot, busy_o=1.
    - beat_done_i increments the beat count and clears the watchdog.
    - Otherwise the watchdog increments.
  - TURN: exactly one cycle with gnt_o=0 and busy_o=0. Arbitration is performed exactly as in IDLE. On a hit the grant is visible next cycle and the state goes to OWN; otherwise it goes to IDLE.
- Release conditions, evaluated in OWN with priority top to bottom:
  - (a) Owner's req_i bit low.
  - (b) beat_done_i with beat count == latched length.
  - (c) Watchdog == TIMEOUT−1 with no beat_done_i this cycle. Also pulse timeout_o next cycle.
- On release:
  - gnt_o=0 next cycle, state TURN.
  - Pointer = owner+1, wrapping N_REQ−1→0.
  - Counters cleared.
  - gnt_id_o holds the owner value until the next grant.
- Timing: last beat_done_i at cycle t → gnt_o low at t+1 → next grant at t+2.
- len_i is sampled only at grant; later changes have no effect on the current burst.
- beat_done_i in IDLE/TURN is ignored.
- Simultaneous (a) and (b): a single release, pointer advanced once.
- N_REQ=1: grant/TURN alternation still holds; pointer stays 0.
- Reset mid-burst: all outputs drop asynchronously. After reset, requester 0 has top priority.
- Widths:
  - Beat count is BURST_W bits. It never wraps because release occurs at equality.
  - Watchdog is $clog2(TIMEOUT) bits and saturates via release.

Decomposition:
- Package arb_pkg holds:
  - State enum typedef (IDLE, OWN, TURN).
  - Default parameter constants.
  - A function computing index width (min 1).
- One sub-module, rr_pick: combinational rotating priority encoder.
  - Inputs: req vector, pointer.
  - Outputs: one-hot, index, any-valid.
  - Instantiated once and shared by the IDLE and TURN arbitration paths.

Test Plan:
- Single requester: req_i=0001, len0=3, beat_done_i every cycle from grant → gnt_o=0001 for 4 cycles, then 0000 for 1 cycle, then regrant 0001 while req held.
- Fairness: req_i=1111 held, all len=0, beat_done_i=1 → gnt_id_o sequence 0,1,2,3,0,… with one dead cycle between grants, no requester skipped.
- Pointer wrap: owner 3 releases with req_i=1001 → next grant to requester 0 (gnt_o=0001), not 3.
- Early drop: owner 2, len=4, drops req after 2 beats → gnt_o=0 next cycle, busy_o=0, pointer=3, timeout_o stays 0.
- Watchdog, TIMEOUT=16: grant then no beat_done_i → timeout_o pulses once exactly 16 owned cycles after grant, gnt_o drops the same cycle, pointer advances.
- Async reset while owning requester 2 mid-burst → gnt_o, busy_o, gnt_id_o go to 0 immediately. With req_i=0110 after reset, the first grant goes to requester 1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin bus arbiter.
// Holds the FSM state encoding and the index-width helper.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_BURST_W = 4;
    localparam int DEF_TIMEOUT = 64;

    // Index width that stays at one bit for a single requester.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping.
// Purely combinational; no internal state.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [idx_w(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]        onehot,
    output logic [idx_w(N_REQ)-1:0] idx,
    output logic                    vld
);

    localparam int IDW = idx_w(N_REQ);

    int cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        vld    = 1'b0;
        cand   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (int'(ptr) + i) % N_REQ;
            if (!vld && req[cand]) begin
                vld          = 1'b1;
                idx          = IDW'(cand);
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin burst arbiter: owner keeps the resource until burst end, request drop or watchdog.
// Grant appears the cycle after the request; one dead TURN cycle separates consecutive owners.
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int BURST_W = DEF_BURST_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*BURST_W-1:0]   len_i,
    input  logic                       beat_done_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic [idx_w(N_REQ)-1:0]    gnt_id_o,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int IDW = idx_w(N_REQ);
    localparam int WDW = $clog2(TIMEOUT);

    state_t             state, state_nxt;
    logic [N_REQ-1:0]   gnt_q, gnt_nxt;
    logic [IDW-1:0]     id_q, id_nxt;
    logic [IDW-1:0]     ptr_q, ptr_nxt;
    logic [BURST_W-1:0] len_q, len_nxt;
    logic [BURST_W-1:0] cnt_q, cnt_nxt;
    logic [WDW-1:0]     wdog_q, wdog_nxt;
    logic               to_q, to_nxt;

    logic [N_REQ-1:0]   pick_onehot;
    logic [IDW-1:0]     pick_idx;
    logic               pick_vld;

    logic               rel_drop, rel_done, rel_to;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req_i),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .vld    (pick_vld)
    );

    // Release causes are ordered: drop beats burst-end beats watchdog.
    assign rel_drop = !req_i[id_q];
    assign rel_done = beat_done_i && (cnt_q == len_q);
    assign rel_to   = !beat_done_i && (wdog_q == WDW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        id_nxt    = id_q;
        ptr_nxt   = ptr_q;
        len_nxt   = len_q;
        cnt_nxt   = cnt_q;
        wdog_nxt  = wdog_q;
        to_nxt    = 1'b0;

        case (state)
            IDLE, TURN: begin
                if (pick_vld) begin
                    state_nxt = OWN;
                    gnt_nxt   = pick_onehot;
                    id_nxt    = pick_idx;
                    len_nxt   = len_i[int'(pick_idx)*BURST_W +: BURST_W];
                    cnt_nxt   = '0;
                    wdog_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            OWN: begin
                if (rel_drop || rel_done || rel_to) begin
                    state_nxt = TURN;
                    gnt_nxt   = '0;
                    ptr_nxt   = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);
                    cnt_nxt   = '0;
                    wdog_nxt  = '0;
                    to_nxt    = !rel_drop && !rel_done && rel_to;
                end else if (beat_done_i) begin
                    cnt_nxt  = cnt_q + BURST_W'(1);
                    wdog_nxt = '0;
                end else begin
                    wdog_nxt = wdog_q + WDW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt_q  <= '0;
            id_q   <= '0;
            ptr_q  <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            wdog_q <= '0;
            to_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            gnt_q  <= gnt_nxt;
            id_q   <= id_nxt;
            ptr_q  <= ptr_nxt;
            len_q  <= len_nxt;
            cnt_q  <= cnt_nxt;
            wdog_q <= wdog_nxt;
            to_q   <= to_nxt;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_id_o  = id_q;
    assign busy_o    = (state == OWN);
    assign timeout_o = to_q;

endmodule
